// File: rtl/can_bus_pkg.sv
// rtl/can_bus_pkg.sv - shared types and constants for the CAN bus bridge and decoder
package can_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_HOLD,
        ST_STROBE,
        ST_RECOVER,
        ST_ACK
    } can_state_t;

    localparam int DEF_ALE_CYCLES      = 2;
    localparam int DEF_STROBE_CYCLES   = 4;
    localparam int DEF_RECOVERY_CYCLES = 2;

    localparam logic [23:0] CAN0_BASE = 24'h500000;
    localparam logic [23:0] CAN1_BASE = 24'h500200;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/can_phase_counter.sv
// rtl/can_phase_counter.sv - loadable down-counter timing each bus-cycle phase
module can_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/can_bus_bridge.sv
// rtl/can_bus_bridge.sv - 68k bus cycle responder driving two Intel-mode CAN controllers
module can_bus_bridge
    import can_bus_pkg::*;
#(
    parameter int ALE_CYCLES      = DEF_ALE_CYCLES,
    parameter int STROBE_CYCLES   = DEF_STROBE_CYCLES,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset_H,
    input  logic       AS_L,
    input  logic       WE_L,
    input  logic [9:1] Address,
    input  logic [7:0] DataIn,
    input  logic       CAN_Enable0_H,
    input  logic       CAN_Enable1_H,
    output logic [7:0] DataOut,
    output logic       Dtack_L,
    output logic       CAN_ALE_H,
    output logic       CAN_CS0_L,
    output logic       CAN_CS1_L,
    output logic       CAN_RD_L,
    output logic       CAN_WR_L,
    output logic [7:0] CAN_AD_Out,
    output logic       CAN_AD_OE_H,
    input  logic [7:0] CAN_AD_In
);

    localparam int MAX_CYC = max3(ALE_CYCLES, STROBE_CYCLES, RECOVERY_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    can_state_t       state;
    logic [7:0]       wr_data;
    logic             is_write;
    logic             sel_can1;
    logic             start;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tc;
    logic             unused_addr9;

    // Address[9] only distinguishes the two controllers' windows, which the decoder already did.
    assign unused_addr9 = Address[9];
    assign start        = !AS_L && (CAN_Enable0_H ^ CAN_Enable1_H);

    // Reload the phase counter on every edge that moves into a timed phase.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        unique case (state)
            ST_IDLE: if (start) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(ALE_CYCLES - 1);
            end
            ST_ADDR: if (cnt_tc) begin
                cnt_load  = 1'b1;
                cnt_value = '0;
            end
            ST_HOLD: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: if (cnt_tc) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(RECOVERY_CYCLES - 1);
            end
            ST_RECOVER: if (cnt_tc) begin
                cnt_load  = 1'b1;
                cnt_value = '0;
            end
            default: ;
        endcase
    end

    can_phase_counter #(.WIDTH(CNT_W)) u_phase (
        .clk        (Clk),
        .reset      (Reset_H),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tc         (cnt_tc)
    );

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state       <= ST_IDLE;
            Dtack_L     <= 1'b1;
            CAN_ALE_H   <= 1'b0;
            CAN_CS0_L   <= 1'b1;
            CAN_CS1_L   <= 1'b1;
            CAN_RD_L    <= 1'b1;
            CAN_WR_L    <= 1'b1;
            CAN_AD_OE_H <= 1'b0;
            CAN_AD_Out  <= '0;
            DataOut     <= '0;
            wr_data     <= '0;
            is_write    <= 1'b0;
            sel_can1    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    wr_data     <= DataIn;
                    is_write    <= !WE_L;
                    sel_can1    <= CAN_Enable1_H;
                    CAN_ALE_H   <= 1'b1;
                    CAN_AD_OE_H <= 1'b1;
                    CAN_AD_Out  <= Address[8:1];
                    state       <= ST_ADDR;
                end
                ST_ADDR: if (cnt_tc) begin
                    CAN_ALE_H <= 1'b0;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    CAN_CS0_L <= sel_can1;
                    CAN_CS1_L <= !sel_can1;
                    if (is_write) begin
                        CAN_WR_L   <= 1'b0;
                        CAN_AD_Out <= wr_data;
                    end else begin
                        CAN_RD_L    <= 1'b0;
                        CAN_AD_OE_H <= 1'b0;
                    end
                    state <= ST_STROBE;
                end
                ST_STROBE: if (cnt_tc) begin
                    CAN_CS0_L <= 1'b1;
                    CAN_CS1_L <= 1'b1;
                    CAN_RD_L  <= 1'b1;
                    CAN_WR_L  <= 1'b1;
                    if (!is_write) begin
                        DataOut <= CAN_AD_In;
                    end
                    state <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    // Write data stays on the bus for exactly one clock after WR_L rises.
                    CAN_AD_OE_H <= 1'b0;
                    if (cnt_tc) begin
                        Dtack_L <= AS_L;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: if (AS_L || Dtack_L) begin
                    Dtack_L <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_bus_bridge.sv
// tb/tb_can_bus_bridge.sv - self-checking bench for can_bus_bridge against a timeline model
module tb_can_bus_bridge;

    localparam int A = 2;
    localparam int S = 4;
    localparam int R = 2;
    localparam int D = A + 1 + S + R;
    localparam logic [6:0] IDLE_CTL = 7'b0111101;

    logic       Clk = 1'b0;
    logic       Reset_H;
    logic       AS_L;
    logic       WE_L;
    logic [9:1] Address;
    logic [7:0] DataIn;
    logic       CAN_Enable0_H;
    logic       CAN_Enable1_H;
    logic [7:0] DataOut;
    logic       Dtack_L;
    logic       CAN_ALE_H;
    logic       CAN_CS0_L;
    logic       CAN_CS1_L;
    logic       CAN_RD_L;
    logic       CAN_WR_L;
    logic [7:0] CAN_AD_Out;
    logic       CAN_AD_OE_H;
    logic [7:0] CAN_AD_In;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_dataout = 8'h00;
    logic [6:0] ctl;

    always #5 Clk = ~Clk;

    assign ctl = {CAN_ALE_H, CAN_CS0_L, CAN_CS1_L, CAN_RD_L, CAN_WR_L, CAN_AD_OE_H, Dtack_L};

    can_bus_bridge dut (
        .Clk           (Clk),
        .Reset_H       (Reset_H),
        .AS_L          (AS_L),
        .WE_L          (WE_L),
        .Address       (Address),
        .DataIn        (DataIn),
        .CAN_Enable0_H (CAN_Enable0_H),
        .CAN_Enable1_H (CAN_Enable1_H),
        .DataOut       (DataOut),
        .Dtack_L       (Dtack_L),
        .CAN_ALE_H     (CAN_ALE_H),
        .CAN_CS0_L     (CAN_CS0_L),
        .CAN_CS1_L     (CAN_CS1_L),
        .CAN_RD_L      (CAN_RD_L),
        .CAN_WR_L      (CAN_WR_L),
        .CAN_AD_Out    (CAN_AD_Out),
        .CAN_AD_OE_H   (CAN_AD_OE_H),
        .CAN_AD_In     (CAN_AD_In)
    );

    task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One CPU access. k counts sampled clocks after the accepting edge E0; r is the
    // first edge at which AS_L is seen high again.
    task automatic run_cycle(input bit wr, input bit ch, input logic [7:0] idx,
                             input logic [7:0] data, input logic [7:0] adin,
                             input int r, input string tag);
        int         k_end;
        logic       strobe;
        logic       exp_oe;
        logic [6:0] exp_ctl;
        k_end         = (r > D + 1) ? r : D + 1;
        Address       = {1'($urandom_range(1)), idx};
        DataIn        = data;
        WE_L          = !wr;
        CAN_Enable0_H = !ch;
        CAN_Enable1_H = ch;
        CAN_AD_In     = adin;
        AS_L          = 1'b0;
        for (int k = 0; k <= k_end; k++) begin
            @(negedge Clk);
            strobe  = (k >= A + 1) && (k <= A + S);
            exp_oe  = (k <= A) || (wr && k >= A + 1 && k <= A + S + 1);
            exp_ctl = {k < A, !(strobe && !ch), !(strobe && ch), !(strobe && !wr),
                       !(strobe && wr), exp_oe, !(k >= D && k < r)};
            if (!wr && k == A + S + 1) exp_dataout = adin;
            check({tag, "_ctl"}, k, {1'b0, ctl}, {1'b0, exp_ctl});
            check({tag, "_dataout"}, k, DataOut, exp_dataout);
            if (exp_oe) check({tag, "_ad_out"}, k, CAN_AD_Out, (k <= A) ? idx : data);
            if (k == r - 1) AS_L = 1'b1;
        end
    endtask

    initial begin
        Reset_H       = 1'b1;
        AS_L          = 1'b1;
        WE_L          = 1'b1;
        Address       = '0;
        DataIn        = 8'h00;
        CAN_Enable0_H = 1'b0;
        CAN_Enable1_H = 1'b0;
        CAN_AD_In     = 8'h00;
        repeat (2) @(negedge Clk);
        check("reset_ctl", 0, {1'b0, ctl}, {1'b0, IDLE_CTL});
        check("reset_ad_out", 0, CAN_AD_Out, 8'h00);
        check("reset_dataout", 0, DataOut, 8'h00);
        Reset_H = 1'b0;
        @(negedge Clk);

        run_cycle(1'b0, 1'b0, 8'h12, 8'h00, 8'hA5, D + 2, "read_can0");
        @(negedge Clk);
        run_cycle(1'b1, 1'b1, 8'h04, 8'h3C, 8'h5A, D + 2, "write_can1");
        @(negedge Clk);

        Address       = {1'b0, 8'h22};
        CAN_Enable0_H = 1'b1;
        CAN_Enable1_H = 1'b1;
        AS_L          = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            check("both_enables_ctl", k, {1'b0, ctl}, {1'b0, IDLE_CTL});
        end
        AS_L          = 1'b1;
        CAN_Enable1_H = 1'b0;
        @(negedge Clk);

        run_cycle(1'b0, 1'b1, 8'($urandom), 8'h00, 8'($urandom), 3, "abort_e3");
        @(negedge Clk);

        Address       = {1'b0, 8'h30};
        WE_L          = 1'b1;
        CAN_Enable0_H = 1'b1;
        CAN_Enable1_H = 1'b0;
        AS_L          = 1'b0;
        repeat (A + 3) @(negedge Clk);
        check("pre_reset_rd", 0, {7'b0, CAN_RD_L}, 8'h00);
        Reset_H = 1'b1;
        @(negedge Clk);
        exp_dataout = 8'h00;
        check("mid_reset_ctl", 0, {1'b0, ctl}, {1'b0, IDLE_CTL});
        check("mid_reset_dataout", 0, DataOut, exp_dataout);
        Reset_H       = 1'b0;
        AS_L          = 1'b1;
        CAN_Enable0_H = 1'b0;
        @(negedge Clk);
        run_cycle(1'b0, 1'b0, 8'($urandom), 8'h00, 8'($urandom), D + 3, "after_reset");

        run_cycle(1'b0, 1'b0, 8'($urandom), 8'h00, 8'($urandom), D + 2, "b2b_first");
        run_cycle(1'b0, 1'b1, 8'($urandom), 8'h00, 8'($urandom), D + 2, "b2b_second");

        for (int i = 0; i < 12; i++) begin
            int r;
            r = ($urandom_range(3) == 0) ? int'($urandom_range(D, 1)) : D + 1 + int'($urandom_range(3));
            run_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
                      8'($urandom), 8'($urandom), r, "random");
            if ($urandom_range(1) == 1) @(negedge Clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
